// File: rtl/draw_scheduler.sv
// draw_scheduler: round-robin arbiter that shares one sprite-plot engine
// among N_REQ requesters. Each grant drives the engine's level-sensitive
// start/coordinate inputs, counts plot strobes to detect job completion,
// and pulses done[winner] once the job finishes or times out.
// Optional feature macro: DRAW_SCHED_ERASE_EN. When defined, each grant
// first erases the requester's previously drawn position (colour 0) and
// then draws at the new coordinates.
module draw_scheduler #(
    parameter int N_REQ        = 4,
    parameter int START_CYCLES = 2,
    parameter int PIXELS       = 16,
    parameter int TIMEOUT      = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [16*N_REQ-1:0]  req_xy,
    input  logic [3*N_REQ-1:0]   req_colour,
    output logic [N_REQ-1:0]     done,
    output logic                 draw_start,
    output logic [15:0]          draw_xy,
    output logic [2:0]           draw_colour,
    input  logic                 draw_plot,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int IW = $clog2(N_REQ);
    localparam int PW = $clog2(PIXELS + 1);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(START_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, START, RELEASE, COUNT, DONE} state_t;

    state_t          state;
    logic [IW-1:0]   last;
    logic [IW-1:0]   winner;
    logic [PW-1:0]   pix;
    logic [CW-1:0]   cyc;
    logic [SW-1:0]   scnt;

    logic [15:0]     xy_arr  [N_REQ];
    logic [2:0]      col_arr [N_REQ];

    logic            found;
    logic [IW-1:0]   pick;
    logic [PW-1:0]   pix_nxt;
    logic [CW-1:0]   cyc_nxt;
    logic            finish_ok;
    logic            tmo;
    logic            job_last;
    logic [N_REQ-1:0] win_oh;

`ifdef DRAW_SCHED_ERASE_EN
    logic [N_REQ-1:0][15:0] last_xy;
    logic [N_REQ-1:0]       last_vld;
    logic [15:0]            pend_xy;
    logic [2:0]             pend_colour;
    logic                   erasing;

    assign job_last = !erasing;
`else
    assign job_last = 1'b1;
`endif

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign xy_arr[g]  = req_xy[16*g +: 16];
        assign col_arr[g] = req_colour[3*g +: 3];
    end

    // Round-robin pick: first asserted request searching upward from last+1.
    always_comb begin
        int idx;
        logic [IW-1:0] idx_w;
        idx   = 0;
        idx_w = '0;
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx   = (int'(last) + k) % N_REQ;
            idx_w = IW'(idx);
            if (!found && req[idx_w]) begin
                found = 1'b1;
                pick  = idx_w;
            end
        end
    end

    // Saturating counter next-values, completion/timeout decode, done mask.
    always_comb begin
        pix_nxt   = (draw_plot && pix != '1) ? pix + PW'(1) : pix;
        cyc_nxt   = (cyc != '1) ? cyc + CW'(1) : cyc;
        finish_ok = (state == COUNT) && (pix_nxt >= PW'(PIXELS));
        tmo       = cyc >= CW'(TIMEOUT - 1);
        win_oh    = '0;
        win_oh[winner] = 1'b1;
    end

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last        <= IW'(N_REQ - 1);
            winner      <= '0;
            pix         <= '0;
            cyc         <= '0;
            scnt        <= '0;
            done        <= '0;
            draw_start  <= 1'b0;
            draw_xy     <= '0;
            draw_colour <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
`ifdef DRAW_SCHED_ERASE_EN
            last_xy     <= '0;
            last_vld    <= '0;
            pend_xy     <= '0;
            pend_colour <= '0;
            erasing     <= 1'b0;
`endif
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        winner     <= pick;
                        last       <= pick;
                        state      <= START;
                        draw_start <= 1'b1;
                        busy       <= 1'b1;
                        scnt       <= '0;
                        pix        <= '0;
                        cyc        <= '0;
`ifdef DRAW_SCHED_ERASE_EN
                        pend_xy     <= xy_arr[pick];
                        pend_colour <= col_arr[pick];
                        if (last_vld[pick]) begin
                            draw_xy     <= last_xy[pick];
                            draw_colour <= 3'b000;
                            erasing     <= 1'b1;
                        end else begin
                            draw_xy     <= xy_arr[pick];
                            draw_colour <= col_arr[pick];
                            erasing     <= 1'b0;
                        end
`else
                        draw_xy     <= xy_arr[pick];
                        draw_colour <= col_arr[pick];
`endif
                    end
                end
                START, RELEASE, COUNT: begin
                    pix <= pix_nxt;
                    cyc <= cyc_nxt;
                    if (finish_ok || tmo) begin
                        // Normal completion wins over a coincident timeout.
                        if (!finish_ok)
                            timeout_err <= 1'b1;
                        state      <= DONE;
                        draw_start <= 1'b0;
                        if (job_last)
                            done <= win_oh;
                    end else if (state == START) begin
                        scnt <= scnt + SW'(1);
                        if (scnt == SW'(START_CYCLES - 1)) begin
                            state      <= RELEASE;
                            draw_start <= 1'b0;
                        end
                    end else if (state == RELEASE) begin
                        state <= COUNT;
                    end
                end
                DONE: begin
`ifdef DRAW_SCHED_ERASE_EN
                    if (erasing) begin
                        // Erase finished: launch the draw job after this gap cycle.
                        erasing     <= 1'b0;
                        draw_xy     <= pend_xy;
                        draw_colour <= pend_colour;
                        state       <= START;
                        draw_start  <= 1'b1;
                        scnt        <= '0;
                        pix         <= '0;
                        cyc         <= '0;
                    end else begin
                        last_xy[winner]  <= draw_xy;
                        last_vld[winner] <= 1'b1;
                        state            <= IDLE;
                        busy             <= 1'b0;
                    end
`else
                    state <= IDLE;
                    busy  <= 1'b0;
`endif
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    draw_start <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_draw_scheduler.sv
// Scoreboard bench for draw_scheduler: stimulus pushes expected jobs, an
// engine model answers draw_start with plot strobes, and a monitor pops
// and compares at every job start and every done pulse.
module tb_draw_scheduler;

    localparam int N_REQ        = 4;
    localparam int START_CYCLES = 2;
    localparam int PIXELS       = 16;
    localparam int TIMEOUT      = 255;
    localparam int NORM_DUR     = START_CYCLES + PIXELS;

    typedef struct {
        int          idx;
        logic [15:0] xy;
        logic [2:0]  colour;
        bit          fin;
        int          dur;
        bit          terr;
    } job_t;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [N_REQ-1:0]     req;
    logic [16*N_REQ-1:0]  req_xy;
    logic [3*N_REQ-1:0]   req_colour;
    logic [N_REQ-1:0]     done;
    logic                 draw_start;
    logic [15:0]          draw_xy;
    logic [2:0]           draw_colour;
    logic                 draw_plot;
    logic                 busy;
    logic                 timeout_err;

    int   checks = 0;
    int   failures = 0;
    int   tcyc = 0;
    int   done_cnt = 0;
    int   plot_n = PIXELS;
    int   eng_plots = 0;
    job_t job_q[$];

    logic [15:0] m_xy  [N_REQ];
    bit          m_vld [N_REQ];

    draw_scheduler #(
        .N_REQ(N_REQ), .START_CYCLES(START_CYCLES),
        .PIXELS(PIXELS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset), .req(req), .req_xy(req_xy),
        .req_colour(req_colour), .done(done), .draw_start(draw_start),
        .draw_xy(draw_xy), .draw_colour(draw_colour), .draw_plot(draw_plot),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) tcyc <= tcyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, tcyc);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_draw_start"}, 32'(draw_start), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 0);
        check({tag, "_draw_xy"}, 32'(draw_xy), 0);
        check({tag, "_draw_colour"}, 32'(draw_colour), 0);
    endtask

    task automatic set_req(input int idx, input logic [15:0] xy, input logic [2:0] col);
        req_xy[16*idx +: 16]  = xy;
        req_colour[3*idx +: 3] = col;
    endtask

    // Push the job(s) one grant should produce; an erase job precedes the
    // draw when the requester has drawn before.
    task automatic expect_grant(input int idx, input logic [15:0] xy, input logic [2:0] col,
                                input int dur, input bit terr);
        job_t j;
`ifdef DRAW_SCHED_ERASE_EN
        if (m_vld[idx]) begin
            j.idx = idx; j.xy = m_xy[idx]; j.colour = 3'd0;
            j.fin = 1'b0; j.dur = 0; j.terr = 1'b0;
            job_q.push_back(j);
        end
        m_vld[idx] = 1'b1;
        m_xy[idx]  = xy;
`endif
        j.idx = idx; j.xy = xy; j.colour = col;
        j.fin = 1'b1; j.dur = dur; j.terr = terr;
        job_q.push_back(j);
    endtask

    task automatic wait_more(input int n, input int budget);
        int target;
        target = done_cnt + n;
        for (int i = 0; i < budget && done_cnt < target; i++) begin
            @(negedge clock); #1;
        end
        check("done_count", 32'(done_cnt), 32'(target));
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    // Engine model: after start is released, emit plot_n strobes.
    initial begin
        int n;
        draw_plot = 1'b0;
        forever begin
            @(posedge clock); #1;
            if (!reset && draw_start) begin
                n = plot_n;
                eng_plots = 0;
                while (draw_start && !reset) begin
                    @(posedge clock); #1;
                end
                for (int k = 0; k < n && !reset; k++) begin
                    draw_plot = 1'b1;
                    @(posedge clock); #1;
                    eng_plots = k + 1;
                end
                draw_plot = 1'b0;
            end
        end
    end

    // Monitor: check each job start against the queue head, each done
    // against the current final job.
    initial begin
        job_t cur;
        bit   have_job = 1'b0;
        bit   prev_start = 1'b0;
        bit   after_done = 1'b0;
        bit   stable = 1'b1;
        int   start_t = 0;
        logic [N_REQ-1:0] exp_oh;
        forever begin
            @(negedge clock);
            if (reset) begin
                have_job = 1'b0; prev_start = 1'b0; after_done = 1'b0;
            end else begin
                if (after_done) begin
                    check("busy_after_done", 32'(busy), 0);
                    after_done = 1'b0;
                end
                if (draw_start && !prev_start) begin
                    check("job_overlap", 32'(have_job && cur.fin), 0);
                    if (job_q.size() == 0) begin
                        check("unexpected_start", 1, 0);
                    end else begin
                        cur = job_q.pop_front();
                        have_job = 1'b1;
                        stable = 1'b1;
                        start_t = tcyc;
                        check("start_xy", 32'(draw_xy), 32'(cur.xy));
                        check("start_colour", 32'(draw_colour), 32'(cur.colour));
                    end
                end
                if (!draw_start && prev_start)
                    check("start_width", 32'(tcyc - start_t), START_CYCLES);
                if (have_job && busy && (draw_xy !== cur.xy || draw_colour !== cur.colour))
                    stable = 1'b0;
                if (done != '0) begin
                    if (!have_job || !cur.fin) begin
                        check("spurious_done", 32'(done), 0);
                    end else begin
                        exp_oh = '0;
                        exp_oh[cur.idx] = 1'b1;
                        check("done_onehot", 32'($onehot(done)), 1);
                        check("done_idx", 32'(done), 32'(exp_oh));
                        check("job_duration", 32'(tcyc - start_t), 32'(cur.dur));
                        check("xy_stable", 32'(stable), 1);
                        check("timeout_err_at_done", 32'(timeout_err), 32'(cur.terr));
                        check("start_in_done", 32'(draw_start), 0);
                        have_job = 1'b0;
                        after_done = 1'b1;
                    end
                    done_cnt++;
                end
                prev_start = draw_start;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int r_t;
        bit hit;
        reset = 1'b1; req = '0; req_xy = '0; req_colour = '0;
        for (int i = 0; i < N_REQ; i++) begin m_vld[i] = 1'b0; m_xy[i] = '0; end
        #1;
        check_idle("reset");
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Contention: 0,1,3,0,1 with requests held.
        set_req(0, 16'h1020, 3'd5);
        set_req(1, 16'h2030, 3'd1);
        set_req(3, 16'h4050, 3'd7);
        expect_grant(0, 16'h1020, 3'd5, NORM_DUR, 1'b0);
        expect_grant(1, 16'h2030, 3'd1, NORM_DUR, 1'b0);
        expect_grant(3, 16'h4050, 3'd7, NORM_DUR, 1'b0);
        expect_grant(0, 16'h1020, 3'd5, NORM_DUR, 1'b0);
        expect_grant(1, 16'h2030, 3'd1, NORM_DUR, 1'b0);
        req = 4'b1011;
        wait_more(5, 600);
        req = '0;

        // Single request with grant latency check.
        idle_cycles(3);
        expect_grant(0, 16'h1020, 3'd5, NORM_DUR, 1'b0);
        req = 4'b0001;
        r_t = tcyc;
        for (int i = 0; i < 10 && !draw_start; i++) begin @(negedge clock); #1; end
        check("grant_latency", 32'(tcyc - r_t), 1);
        wait_more(1, 200);
        req = '0;

        // Timeout: engine short by 6 plots.
        idle_cycles(3);
        plot_n = 10;
        set_req(1, 16'h0a0b, 3'd6);
        expect_grant(1, 16'h0a0b, 3'd6, TIMEOUT, 1'b1);
        req = 4'b0010;
        wait_more(1, 800);
        req = '0;
        plot_n = PIXELS;
        idle_cycles(3);
        check("timeout_err_sticky_idle", 32'(timeout_err), 1);
        expect_grant(3, 16'h4050, 3'd7, NORM_DUR, 1'b1);
        req = 4'b1000;
        wait_more(1, 200);
        req = '0;

        // Request dropped and inputs changed mid-job.
        idle_cycles(3);
        set_req(2, 16'h3344, 3'd2);
        expect_grant(2, 16'h3344, 3'd2, NORM_DUR, 1'b1);
        req = 4'b0100;
        for (int i = 0; i < 10 && !draw_start; i++) begin @(negedge clock); #1; end
        req[2] = 1'b0;
        set_req(2, 16'hAAAA, 3'd1);
        wait_more(1, 200);

        // Reset in COUNT after 7 plots.
        idle_cycles(3);
        expect_grant(0, 16'h1020, 3'd5, NORM_DUR, 1'b1);
        req = 4'b0001;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(posedge clock); #2;
            if (eng_plots == 7 && busy) hit = 1'b1;
        end
        check("plots_before_reset", 32'(hit), 1);
        reset = 1'b1;
        #1;
        check_idle("midjob_reset");
        job_q.delete();
        for (int i = 0; i < N_REQ; i++) m_vld[i] = 1'b0;
        req = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        set_req(0, 16'h1111, 3'd3);
        set_req(1, 16'h2222, 3'd4);
        expect_grant(0, 16'h1111, 3'd3, NORM_DUR, 1'b0);
        expect_grant(1, 16'h2222, 3'd4, NORM_DUR, 1'b0);
        req = 4'b0011;
        wait_more(2, 200);
        req = '0;

`ifdef DRAW_SCHED_ERASE_EN
        // Erase-before-draw: second grant erases 0505 then draws 0605.
        idle_cycles(3);
        set_req(1, 16'h0505, 3'd3);
        expect_grant(1, 16'h0505, 3'd3, NORM_DUR, 1'b0);
        req = 4'b0010;
        wait_more(1, 200);
        req = '0;
        idle_cycles(3);
        set_req(1, 16'h0605, 3'd4);
        expect_grant(1, 16'h0605, 3'd4, NORM_DUR, 1'b0);
        req = 4'b0010;
        wait_more(1, 300);
        req = '0;
`endif

        idle_cycles(5);
        check("queue_empty", 32'(job_q.size()), 0);
        check("final_busy", 32'(busy), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
